irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
// PURPOSE
//  Interrupt aggregator between the gpio0/gpio1 irq outputs and the CPLD interrupt pin (RCW_SRC2 pad).
//  Synchronises up to 8 sources, latches edges into a pending register and applies a per-source enable mask.
//  Drives one registered interrupt line.
//  Register bank on the shared 5-bit CSR bus; csr_do is OR-combined with the other blocks.
// PARAMETERS
//  BASE_ADDR     5'h18   first of 3 consecutive CSR addresses
//  NUM_IRQS      8       number of sources, 1..8; unused register bits read 0 and ignore writes
//  DFL_IE        8'h00   enable mask value after reset
//  DFL_EDGE      8'hff   sense-select value after reset (1 = rising edge, 0 = level)
//  RETRIG_CYCLES 4       low time of irq_out on retrigger, 1..15 (used only with IRQ_CTRL_RETRIGGER_EN)
// PORTS
//  clk      in   1         system clock
//  rst      in   1         asynchronous reset, active-high
//  csr_a    in   5         CSR address
//  csr_di   in   8         CSR write data
//  csr_we   in   1         CSR write strobe, one clk cycle
//  csr_do   out  8         CSR read data, combinational; 0 when csr_a is outside this block
//  irq_in   in   NUM_IRQS  raw source levels, active-high, asynchronous to clk
//  irq_out  out  1         aggregated interrupt, active-high, registered
// BEHAVIOUR
//  Clock and reset
//  - One clock; reset is asynchronous and active-high.
//  - Reset values: sync chain=0, pending=0, ie=DFL_IE, edge=DFL_EDGE, irq_out=0, retrigger counter=0.
//  Register map (offset from BASE_ADDR)
//  - +0 IE (RW): enable mask.
//  - +1 IP (R/W1C): pending bits; writing 1 clears a bit, writing 0 has no effect.
//  - +2 EDGE (RW): sense select.
//  Synchronisation and edge detect
//  - irq_in passes through 2 synchroniser flops (s1, s2), then a third stage s3 for edge detect.
//  - Edge source: s2 & ~s3 sets pending on the next clk.
//  - Level source: pending <= s2 every cycle; W1C to that bit is ignored.
//  - Pending latches regardless of IE; IE gates only irq_out.
//  Output and latency
//  - irq_out <= |(pending & ie), registered.
//  - Latency: irq_in rising sampled at edge N gives irq_out=1 after edge N+3.
//  Boundary conditions
//  - W1C and a new edge on the same bit in the same cycle: the set wins, bit stays 1.
//  - IE write: takes effect on irq_out one cycle after the write.
//  - Clearing IE does not clear pending; re-enabling re-asserts irq_out if the bit is still pending.
//  - Changing EDGE from level to edge: pending keeps its current value.
//  - Changing EDGE from edge to level: pending follows s2 from the next cycle.
//  - rst mid-operation: all state returns to reset values immediately; no glitch on irq_out beyond the async clear.
//  - csr_we to an unmapped or out-of-range address: no state change.
// CONFIGURATION
//  IRQ_CTRL_RETRIGGER_EN defined
//  - Trigger: a W1C write clears >=1 pending bit, and the next-cycle value of |(pending & ie) is still 1.
//  - Effect: irq_out is forced 0 for RETRIG_CYCLES cycles, then follows the normal rule; this gives edge-triggered hosts a fresh edge.
//  - A further qualifying write during the low window reloads the counter.
//  - rst clears the counter.
//  IRQ_CTRL_RETRIGGER_EN undefined
//  - irq_out is a plain registered level; the counter logic is absent and RETRIG_CYCLES is unused.
// TESTING
//  - Reset/readback: release rst -> read +0 = DFL_IE, +1 = 0, +2 = DFL_EDGE; irq_out = 0.
//  - Latency: IE=8'h01, EDGE=8'h01, pulse irq_in[0] for 1 cycle -> IP=8'h01, irq_out=1 exactly 3 edges after the sampling edge; write +1=8'h01 -> irq_out=0 two cycles later.
//  - Level source: EDGE=8'h00, IE=8'h04, hold irq_in[2]=1 -> write +1=8'h04 leaves IP=8'h04; drop irq_in[2] -> IP=0, irq_out=0 after 4 cycles.
//  - Set beats clear: edge on irq_in[3] in the same cycle as W1C 8'h08 -> IP[3]=1.
//  - Mask: IE=0 with an edge on irq_in[1] -> IP=8'h02, irq_out=0; write IE=8'h02 -> irq_out=1 next-plus-one cycle.
//  - Retrigger (macro on, RETRIG_CYCLES=4): IP=8'h03, IE=8'h03, write +1=8'h01 -> irq_out low for exactly 4 cycles, then 1; with the macro off -> irq_out stays 1.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: aggregates up to 8 asynchronous interrupt sources into one
// registered interrupt line. Each source has a 2-flop synchroniser and an
// edge-detect stage. Pending bits are latched per source, and a per-source
// enable mask gates them. The CSR bank holds IE, IP (write-1-to-clear) and
// EDGE, at three consecutive addresses from BASE_ADDR.
// Optional feature macro: IRQ_CTRL_RETRIGGER_EN. When it is defined, irq_out
// is pulled low for RETRIG_CYCLES cycles after a W1C write that leaves other
// enabled interrupts pending.
module irq_ctrl #(
    parameter logic [4:0] BASE_ADDR     = 5'h18,
    parameter int         NUM_IRQS      = 8,
    parameter logic [7:0] DFL_IE        = 8'h00,
    parameter logic [7:0] DFL_EDGE      = 8'hff,
    parameter int         RETRIG_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          csr_a,
    input  logic [7:0]          csr_di,
    input  logic                csr_we,
    output logic [7:0]          csr_do,
    input  logic [NUM_IRQS-1:0] irq_in,
    output logic                irq_out
);

    // Bits at or above NUM_IRQS do not exist: they read 0 and ignore writes.
    localparam logic [8:0] MASK_WIDE = (9'h001 << NUM_IRQS) - 9'h001;
    localparam logic [7:0] IRQ_MASK  = MASK_WIDE[7:0];

    localparam logic [4:0] ADDR_IE   = BASE_ADDR;
    localparam logic [4:0] ADDR_IP   = BASE_ADDR + 5'd1;
    localparam logic [4:0] ADDR_EDGE = BASE_ADDR + 5'd2;

    if (NUM_IRQS < 1 || NUM_IRQS > 8) begin : g_bad_num_irqs
        $error("irq_ctrl: NUM_IRQS must be 1..8");
    end
    if (RETRIG_CYCLES < 1 || RETRIG_CYCLES > 15) begin : g_bad_retrig
        $error("irq_ctrl: RETRIG_CYCLES must be 1..15");
    end

    logic [7:0] irq_ext_s;
    logic [7:0] s1_r, s2_r, s3_r;
    logic [7:0] pend_r, ie_r, edge_r;
    logic [7:0] pend_nxt_s, ie_nxt_s, edge_nxt_s;
    logic [7:0] w1c_s, rise_s;
    logic       we_ie_s, we_ip_s, we_edge_s;
    logic       irq_nxt_s;
    logic       irq_r;

    // Widen the source vector to the full 8-bit register width.
    always_comb begin
        irq_ext_s = 8'h00;
        irq_ext_s[NUM_IRQS-1:0] = irq_in;
    end

    // Decode CSR write strobes. Unmapped addresses produce no strobe.
    always_comb begin
        we_ie_s   = 1'b0;
        we_ip_s   = 1'b0;
        we_edge_s = 1'b0;
        if (csr_we) begin
            case (csr_a)
                ADDR_IE:   we_ie_s   = 1'b1;
                ADDR_IP:   we_ip_s   = 1'b1;
                ADDR_EDGE: we_edge_s = 1'b1;
                default: begin
                    we_ie_s   = 1'b0;
                    we_ip_s   = 1'b0;
                    we_edge_s = 1'b0;
                end
            endcase
        end else begin
            we_ie_s   = 1'b0;
            we_ip_s   = 1'b0;
            we_edge_s = 1'b0;
        end
    end

    // Combinational read mux. It drives 0 outside this block so the bus can OR.
    always_comb begin
        case (csr_a)
            ADDR_IE:   csr_do = ie_r;
            ADDR_IP:   csr_do = pend_r;
            ADDR_EDGE: csr_do = edge_r;
            default:   csr_do = 8'h00;
        endcase
    end

    // Next-state logic for the pending, enable and sense registers.
    // For edge sources, a new edge beats a simultaneous W1C.
    // Level sources copy s2 and ignore W1C.
    always_comb begin
        if (we_ip_s) begin
            w1c_s = csr_di & IRQ_MASK;
        end else begin
            w1c_s = 8'h00;
        end
        rise_s     = s2_r & ~s3_r & edge_r;
        pend_nxt_s = ((edge_r & ((pend_r & ~w1c_s) | rise_s)) | (~edge_r & s2_r)) & IRQ_MASK;
        if (we_ie_s) begin
            ie_nxt_s = csr_di & IRQ_MASK;
        end else begin
            ie_nxt_s = ie_r;
        end
        if (we_edge_s) begin
            edge_nxt_s = csr_di & IRQ_MASK;
        end else begin
            edge_nxt_s = edge_r;
        end
    end

    // Synchroniser chain, CSR state and the registered interrupt output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_r   <= 8'h00;
            s2_r   <= 8'h00;
            s3_r   <= 8'h00;
            pend_r <= 8'h00;
            ie_r   <= DFL_IE & IRQ_MASK;
            edge_r <= DFL_EDGE & IRQ_MASK;
            irq_r  <= 1'b0;
        end else begin
            s1_r   <= irq_ext_s;
            s2_r   <= s1_r;
            s3_r   <= s2_r;
            pend_r <= pend_nxt_s;
            ie_r   <= ie_nxt_s;
            edge_r <= edge_nxt_s;
            irq_r  <= irq_nxt_s;
        end
    end

`ifdef IRQ_CTRL_RETRIGGER_EN
    localparam logic [3:0] RETRIG_LOAD = 4'(RETRIG_CYCLES);

    logic [3:0] cnt_r, cnt_nxt_s;
    logic [7:0] cleared_s;
    logic       trig_s;

    // Retrigger detection. A W1C write that really clears an edge bit while
    // other enabled interrupts stay pending reloads the low-window counter.
    // irq_out stays low while the counter is non-zero.
    always_comb begin
        cleared_s = w1c_s & pend_r & edge_r & ~rise_s;
        trig_s    = (cleared_s != 8'h00) && ((pend_nxt_s & ie_r) != 8'h00);
        if (trig_s) begin
            cnt_nxt_s = RETRIG_LOAD;
        end else if (cnt_r != 4'd0) begin
            cnt_nxt_s = cnt_r - 4'd1;
        end else begin
            cnt_nxt_s = 4'd0;
        end
        if (cnt_nxt_s != 4'd0) begin
            irq_nxt_s = 1'b0;
        end else begin
            irq_nxt_s = |(pend_r & ie_r);
        end
    end

    // Low-window counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 4'd0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end
`else
    // Plain level output: any enabled pending bit raises the line.
    always_comb begin
        irq_nxt_s = |(pend_r & ie_r);
    end
`endif

    assign irq_out = irq_r;

endmodule

// File: tb/tb_irq_ctrl.sv
// Testbench for irq_ctrl. Directed stimulus pushes hand-computed expectations
// into a scoreboard queue. A monitor pops an entry and compares it on the
// falling edge whenever a sample is requested.
module tb_irq_ctrl;

    localparam logic [4:0] A_IE   = 5'h18;
    localparam logic [4:0] A_IP   = 5'h19;
    localparam logic [4:0] A_EDGE = 5'h1a;

`ifdef IRQ_CTRL_RETRIGGER_EN
    localparam bit RETRIG_ON = 1'b1;
`else
    localparam bit RETRIG_ON = 1'b0;
`endif

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic [4:0] csr_a  = 5'h00;
    logic [7:0] csr_di = 8'h00;
    logic       csr_we = 1'b0;
    logic [7:0] csr_do;
    logic [7:0] irq_in = 8'h00;
    logic       irq_out;

    typedef struct {
        logic       is_irq;
        logic [7:0] exp;
        string      tag;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       cur_e;
    logic [7:0] act_v;
    logic       mon_req   = 1'b0;
    int         pass_cnt  = 0;
    int         total_cnt = 0;

    irq_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .csr_a   (csr_a),
        .csr_di  (csr_di),
        .csr_we  (csr_we),
        .csr_do  (csr_do),
        .irq_in  (irq_in),
        .irq_out (irq_out)
    );

    always #5 clk = ~clk;

    // Monitor: when a sample is requested, pop the expectation and compare it.
    always @(negedge clk) begin
        if (mon_req) begin
            total_cnt++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_empty: sample requested, got no expectation, required one");
            end else begin
                cur_e = sb_q.pop_front();
                act_v = cur_e.is_irq ? {7'b0000000, irq_out} : csr_do;
                if (act_v === cur_e.exp) begin
                    pass_cnt++;
                end else begin
                    $display("FAIL %s: got %02h required %02h", cur_e.tag, act_v, cur_e.exp);
                end
            end
        end
    end

    // Watchdog: stop the run if it is still going after the time limit.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [4:0] a, input logic [7:0] d);
        csr_a  = a;
        csr_di = d;
        csr_we = 1'b1;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic push_chk(input logic k, input logic [7:0] e, input string t);
        exp_t x;
        x.is_irq = k;
        x.exp    = e;
        x.tag    = t;
        sb_q.push_back(x);
        mon_req = 1'b1;
        @(negedge clk);
        #1;
        mon_req = 1'b0;
    endtask

    task automatic chk_rd(input logic [4:0] a, input logic [7:0] e, input string t);
        csr_a = a;
        push_chk(1'b0, e, t);
    endtask

    task automatic chk_irq(input logic e, input string t);
        push_chk(1'b1, {7'b0000000, e}, t);
    endtask

    initial begin
        // Reset and readback of the default register values.
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk_irq(1'b0, "rst_irq");
        chk_rd(A_IE,   8'h00, "rst_ie");
        chk_rd(A_IP,   8'h00, "rst_ip");
        chk_rd(A_EDGE, 8'hff, "rst_edge");

        // Latency: the sampling edge is N, and irq_out rises after N+3.
        csr_wr(A_IE,   8'h01);
        csr_wr(A_EDGE, 8'h01);
        irq_in = 8'h01;
        tick();
        irq_in = 8'h00;
        chk_irq(1'b0, "lat_n0");
        for (int k = 1; k < 4; k++) begin
            tick();
            chk_irq((k == 3), "lat_n");
        end
        chk_rd(A_IP, 8'h01, "lat_ip");
        csr_wr(A_IP, 8'h01);
        chk_irq(1'b1, "w1c_n0");
        tick();
        chk_irq(1'b0, "w1c_n1");
        chk_rd(A_IP, 8'h00, "w1c_ip");

        // Level source: a W1C write is ignored, and pending follows the input.
        csr_wr(A_EDGE, 8'h00);
        csr_wr(A_IE,   8'h04);
        irq_in = 8'h04;
        repeat (4) tick();
        chk_rd(A_IP, 8'h04, "lvl_set");
        csr_wr(A_IP, 8'h04);
        chk_rd(A_IP, 8'h04, "lvl_w1c_ignored");
        chk_irq(1'b1, "lvl_irq");
        irq_in = 8'h00;
        for (int k = 1; k < 5; k++) begin
            tick();
            chk_irq((k < 4), "lvl_drop");
        end
        chk_rd(A_IP, 8'h00, "lvl_ip_clr");

        // A new edge beats a W1C write to the same bit in the same cycle.
        csr_wr(A_EDGE, 8'h08);
        irq_in = 8'h08;
        tick();
        tick();
        csr_wr(A_IP, 8'h08);
        chk_rd(A_IP, 8'h08, "set_wins");
        irq_in = 8'h00;

        // Mask: pending latches while IE=0, and enabling raises irq_out.
        csr_wr(A_IE,   8'h00);
        csr_wr(A_EDGE, 8'h0a);
        csr_wr(A_IP,   8'h08);
        irq_in = 8'h02;
        tick();
        irq_in = 8'h00;
        repeat (3) tick();
        chk_rd(A_IP, 8'h02, "mask_ip");
        chk_irq(1'b0, "mask_irq");
        csr_wr(A_IE, 8'h02);
        chk_irq(1'b0, "ie_n0");
        tick();
        chk_irq(1'b1, "ie_n1");

        // Retrigger: clear one of two pending enabled bits.
        csr_wr(A_EDGE, 8'h03);
        csr_wr(A_IE,   8'h03);
        irq_in = 8'h03;
        tick();
        irq_in = 8'h00;
        repeat (3) tick();
        chk_rd(A_IP, 8'h03, "rt_ip");
        chk_irq(1'b1, "rt_irq");
        csr_wr(A_IP, 8'h01);
        for (int k = 0; k < 6; k++) begin
            chk_irq(RETRIG_ON ? (k >= 4) : 1'b1, "rt_window");
            tick();
        end
        chk_rd(A_IP, 8'h02, "rt_ip_after");

        // Writes to unmapped addresses change nothing, and unmapped reads return 0.
        csr_wr(5'h00, 8'hff);
        csr_wr(5'h1b, 8'hff);
        csr_wr(5'h17, 8'hff);
        chk_rd(A_IE,   8'h03, "unmap_ie");
        chk_rd(A_IP,   8'h02, "unmap_ip");
        chk_rd(A_EDGE, 8'h03, "unmap_edge");
        chk_rd(5'h1b,  8'h00, "unmap_rd");

        // Asynchronous reset in mid-operation clears irq_out within the cycle.
        chk_irq(1'b1, "pre_rst");
        tick();
        rst = 1'b1;
        chk_irq(1'b0, "async_rst");
        tick();
        rst = 1'b0;
        chk_rd(A_IE,   8'h00, "rst2_ie");
        chk_rd(A_IP,   8'h00, "rst2_ip");
        chk_rd(A_EDGE, 8'hff, "rst2_edge");

        tick();
        total_cnt++;
        if (sb_q.size() == 0) begin
            pass_cnt++;
        end else begin
            $display("FAIL sb_drain: got %0d leftover entries, required 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
